// File: rtl/cpu_types_pkg.sv
// Shared CPU types: machine word, JumpSel encodings and the fetch-side state enum.
package cpu_types_pkg;

    typedef logic [31:0] word_t;

    localparam logic [1:0] JSEL_SEQ  = 2'b00;
    localparam logic [1:0] JSEL_JUMP = 2'b01;
    localparam logic [1:0] JSEL_JR   = 2'b10;

    typedef enum logic [1:0] {
        FETCH,
        DATA,
        HALTED
    } fetch_state_t;

    function automatic logic branchTaken(input logic beq, input logic bne, input logic zero);
        return (beq & zero) | (bne & ~zero);
    endfunction

endpackage

// File: rtl/fetch_request_unit_if.sv
// Bundle of fetch/request-unit signals, with a unit-side and a bench-side view.
interface fetch_request_unit_if;
    import cpu_types_pkg::*;

    logic  ihit;
    logic  dhit;
    word_t imemload;
    logic  [1:0] JumpSel;
    logic  BEQ;
    logic  BNE;
    logic  zero;
    logic  halt;
    logic  dREN;
    logic  dWEN;
    word_t rs_data;
    word_t imemaddr;
    logic  imemREN;
    logic  dmemREN;
    logic  dmemWEN;
    word_t instr;
    word_t pc_plus4;
    logic  halted;

    modport fu (
        input  ihit, dhit, imemload, JumpSel, BEQ, BNE, zero, halt, dREN, dWEN, rs_data,
        output imemaddr, imemREN, dmemREN, dmemWEN, instr, pc_plus4, halted
    );

    modport tb (
        output ihit, dhit, imemload, JumpSel, BEQ, BNE, zero, halt, dREN, dWEN, rs_data,
        input  imemaddr, imemREN, dmemREN, dmemWEN, instr, pc_plus4, halted
    );

endinterface

// File: rtl/next_pc_logic.sv
// Combinational next-PC selection: sequential, branch, J/JAL target or JR register.
module next_pc_logic
    import cpu_types_pkg::*;
(
    input  word_t       pc,
    input  logic [25:0] instrIndex,
    input  logic [1:0]  jumpSel,
    input  logic        beq,
    input  logic        bne,
    input  logic        zero,
    input  word_t       rsData,
    output word_t       pcPlus4,
    output word_t       nextPc
);

    word_t branchOffset;
    word_t branchTarget;

    assign pcPlus4      = pc + 32'd4;
    assign branchOffset = {{14{instrIndex[15]}}, instrIndex[15:0], 2'b00};
    assign branchTarget = pcPlus4 + branchOffset;

    // JumpSel 11 falls into the default arm and behaves like sequential/branch.
    always_comb begin
        nextPc = pcPlus4;
        case (jumpSel)
            JSEL_JUMP: nextPc = {pcPlus4[31:28], instrIndex, 2'b00};
            JSEL_JR:   nextPc = rsData;
            default:   nextPc = branchTaken(beq, bne, zero) ? branchTarget : pcPlus4;
        endcase
    end

endmodule

// File: rtl/fetch_request_unit.sv
// Instruction-side front end: owns the PC, issues imem reads and sequences dmem requests.
module fetch_request_unit
    import cpu_types_pkg::*;
#(
    parameter word_t PC_INIT = 32'h0000_0000
) (
    input  logic        CLK,
    input  logic        nRST,
    input  logic        ihit,
    input  logic        dhit,
    input  logic [31:0] imemload,
    input  logic [1:0]  JumpSel,
    input  logic        BEQ,
    input  logic        BNE,
    input  logic        zero,
    input  logic        halt,
    input  logic        dREN,
    input  logic        dWEN,
    input  logic [31:0] rs_data,
    output logic [31:0] imemaddr,
    output logic        imemREN,
    output logic        dmemREN,
    output logic        dmemWEN,
    output logic [31:0] instr,
    output logic [31:0] pc_plus4,
    output logic        halted
);

    fetch_state_t state, stateNext;
    word_t        pc, pcNext;
    word_t        instrQ, instrQNext;
    logic         drenQ, drenQNext;
    logic         dwenQ, dwenQNext;
    logic         haltedQ, haltedQNext;
    word_t        nextPc;

    next_pc_logic uNextPc (
        .pc         (pc),
        .instrIndex (instr[25:0]),
        .jumpSel    (JumpSel),
        .beq        (BEQ),
        .bne        (BNE),
        .zero       (zero),
        .rsData     (rs_data),
        .pcPlus4    (pc_plus4),
        .nextPc     (nextPc)
    );

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            state   <= FETCH;
            pc      <= PC_INIT;
            instrQ  <= '0;
            drenQ   <= 1'b0;
            dwenQ   <= 1'b0;
            haltedQ <= 1'b0;
        end else begin
            state   <= stateNext;
            pc      <= pcNext;
            instrQ  <= instrQNext;
            drenQ   <= drenQNext;
            dwenQ   <= dwenQNext;
            haltedQ <= haltedQNext;
        end
    end

    // The PC only advances on the edge that retires an instruction: ihit for
    // plain instructions, dhit for loads/stores (which hold the PC through DATA).
    always_comb begin
        stateNext   = state;
        pcNext      = pc;
        instrQNext  = instrQ;
        drenQNext   = drenQ;
        dwenQNext   = dwenQ;
        haltedQNext = haltedQ;
        imemREN     = 1'b0;
        dmemREN     = 1'b0;
        dmemWEN     = 1'b0;
        instr       = instrQ;

        case (state)
            FETCH: begin
                imemREN = 1'b1;
                instr   = imemload;
                if (ihit) begin
                    if (halt) begin
                        stateNext   = HALTED;
                        haltedQNext = 1'b1;
                    end else if (dREN || dWEN) begin
                        stateNext  = DATA;
                        instrQNext = imemload;
                        drenQNext  = dREN & ~dWEN;
                        dwenQNext  = dWEN;
                    end else begin
                        pcNext = nextPc;
                    end
                end
            end
            DATA: begin
                dmemREN = drenQ & ~dwenQ;
                dmemWEN = dwenQ;
                if (dhit) begin
                    pcNext    = nextPc;
                    stateNext = FETCH;
                end
            end
            HALTED: begin
                stateNext = HALTED;
            end
            default: begin
                stateNext = FETCH;
            end
        endcase
    end

    assign imemaddr = pc;
    assign halted   = haltedQ;

endmodule

// File: tb/tb_fetch_request_unit.sv
// Directed self-checking bench for fetch_request_unit with hand-computed PC values.
module tb_fetch_request_unit;

    logic        CLK = 1'b0;
    logic        nRST;
    logic        ihit, dhit;
    logic [31:0] imemload;
    logic [1:0]  JumpSel;
    logic        BEQ, BNE, zero, halt, dREN, dWEN;
    logic [31:0] rs_data;
    logic [31:0] imemaddr;
    logic        imemREN, dmemREN, dmemWEN;
    logic [31:0] instr;
    logic [31:0] pc_plus4;
    logic        halted;

    int checks   = 0;
    int failures = 0;

    always #5 CLK = ~CLK;

    fetch_request_unit #(.PC_INIT(32'h0000_0000)) dut (
        .CLK      (CLK),
        .nRST     (nRST),
        .ihit     (ihit),
        .dhit     (dhit),
        .imemload (imemload),
        .JumpSel  (JumpSel),
        .BEQ      (BEQ),
        .BNE      (BNE),
        .zero     (zero),
        .halt     (halt),
        .dREN     (dREN),
        .dWEN     (dWEN),
        .rs_data  (rs_data),
        .imemaddr (imemaddr),
        .imemREN  (imemREN),
        .dmemREN  (dmemREN),
        .dmemWEN  (dmemWEN),
        .instr    (instr),
        .pc_plus4 (pc_plus4),
        .halted   (halted)
    );

    task automatic clearInputs();
        ihit = 0; dhit = 0; imemload = 32'h0; JumpSel = 2'b00;
        BEQ = 0; BNE = 0; zero = 0; halt = 0; dREN = 0; dWEN = 0; rs_data = 32'h0;
    endtask

    task automatic stepCycle();
        @(posedge CLK);
        #1;
    endtask

    // Steers the PC with a JR so later scenarios start at a chosen address.
    task automatic setPc(input logic [31:0] addr);
        clearInputs();
        ihit = 1; JumpSel = 2'b10; rs_data = addr;
        stepCycle();
        clearInputs();
    endtask

    task automatic test_reset();
        clearInputs();
        nRST = 0;
        #3;
        checks++;
        if (imemaddr !== 32'h0 || imemREN !== 1'b1 || dmemREN !== 1'b0 || dmemWEN !== 1'b0 || halted !== 1'b0) begin
            failures++;
            $display("[TB] FAIL reset: addr=%h iren=%b dren=%b dwen=%b halted=%b, want 0/1/0/0/0",
                     imemaddr, imemREN, dmemREN, dmemWEN, halted);
        end
        stepCycle();
        nRST = 1;
    endtask

    task automatic test_sequential();
        logic [31:0] expAddr [4];
        expAddr = '{32'h0, 32'h4, 32'h8, 32'hC};
        clearInputs();
        ihit = 1;
        for (int i = 0; i < 4; i++) begin
            checks++;
            if (imemaddr !== expAddr[i] || imemREN !== 1'b1) begin
                failures++;
                $display("[TB] FAIL seq[%0d]: addr=%h iren=%b, want %h/1", i, imemaddr, imemREN, expAddr[i]);
            end
            if (i < 3) stepCycle();
        end
        clearInputs();
    endtask

    task automatic test_load();
        setPc(32'h10);
        imemload = 32'h8C22_0000;
        ihit = 1; dREN = 1;
        stepCycle();
        imemload = 32'hDEAD_BEEF;
        for (int i = 0; i < 3; i++) begin
            checks++;
            if (dmemREN !== 1'b1 || imemREN !== 1'b0 || imemaddr !== 32'h10 || instr !== 32'h8C22_0000) begin
                failures++;
                $display("[TB] FAIL load_wait[%0d]: dren=%b iren=%b addr=%h instr=%h, want 1/0/00000010/8c220000",
                         i, dmemREN, imemREN, imemaddr, instr);
            end
            if (i < 2) stepCycle();
        end
        dhit = 1;
        stepCycle();
        checks++;
        if (imemaddr !== 32'h14 || dmemREN !== 1'b0 || imemREN !== 1'b1) begin
            failures++;
            $display("[TB] FAIL load_done: addr=%h dren=%b iren=%b, want 00000014/0/1", imemaddr, dmemREN, imemREN);
        end
        clearInputs();
    endtask

    task automatic test_branch();
        logic       beqV [4];
        logic       bneV [4];
        logic       zeroV [4];
        logic [31:0] expPc [4];
        beqV  = '{1'b1, 1'b1, 1'b0, 1'b0};
        bneV  = '{1'b0, 1'b0, 1'b1, 1'b1};
        zeroV = '{1'b1, 1'b0, 1'b0, 1'b1};
        expPc = '{32'h1C, 32'h24, 32'h1C, 32'h24};
        for (int i = 0; i < 4; i++) begin
            setPc(32'h20);
            imemload = {6'h04, 5'd1, 5'd2, 16'hFFFE};
            ihit = 1; BEQ = beqV[i]; BNE = bneV[i]; zero = zeroV[i];
            stepCycle();
            checks++;
            if (imemaddr !== expPc[i]) begin
                failures++;
                $display("[TB] FAIL branch[%0d]: pc=%h, want %h", i, imemaddr, expPc[i]);
            end
        end
        clearInputs();
    endtask

    task automatic test_jump();
        setPc(32'h4000_0000);
        imemload = {6'h02, 26'h000_0100};
        ihit = 1; JumpSel = 2'b01; BEQ = 1; zero = 1;
        stepCycle();
        checks++;
        if (imemaddr !== 32'h4000_0400) begin
            failures++;
            $display("[TB] FAIL jump_j: pc=%h, want 40000400", imemaddr);
        end
        clearInputs();
        ihit = 1; JumpSel = 2'b10; rs_data = 32'h0000_0ABC;
        stepCycle();
        checks++;
        if (imemaddr !== 32'h0000_0ABC) begin
            failures++;
            $display("[TB] FAIL jump_jr: pc=%h, want 00000abc", imemaddr);
        end
        clearInputs();
        imemload = {6'h04, 5'd1, 5'd2, 16'h0004};
        ihit = 1; JumpSel = 2'b11; BEQ = 1; zero = 1;
        stepCycle();
        checks++;
        if (imemaddr !== 32'h0000_0AD0) begin
            failures++;
            $display("[TB] FAIL jsel11_branch: pc=%h, want 00000ad0", imemaddr);
        end
        clearInputs();
    endtask

    task automatic test_wrap();
        setPc(32'hFFFF_FFFC);
        checks++;
        if (pc_plus4 !== 32'h0) begin
            failures++;
            $display("[TB] FAIL wrap_plus4: pc_plus4=%h, want 00000000", pc_plus4);
        end
        ihit = 1;
        stepCycle();
        checks++;
        if (imemaddr !== 32'h0) begin
            failures++;
            $display("[TB] FAIL wrap: pc=%h, want 00000000", imemaddr);
        end
        clearInputs();
    endtask

    task automatic test_both_dmem();
        setPc(32'h60);
        ihit = 1; dREN = 1; dWEN = 1;
        stepCycle();
        checks++;
        if (dmemWEN !== 1'b1 || dmemREN !== 1'b0) begin
            failures++;
            $display("[TB] FAIL both_dmem: dwen=%b dren=%b, want 1/0", dmemWEN, dmemREN);
        end
        clearInputs();
        dhit = 1;
        stepCycle();
        checks++;
        if (imemaddr !== 32'h64 || dmemWEN !== 1'b0) begin
            failures++;
            $display("[TB] FAIL both_dmem_done: pc=%h dwen=%b, want 00000064/0", imemaddr, dmemWEN);
        end
        clearInputs();
    endtask

    task automatic test_halt();
        int badCycles;
        setPc(32'h30);
        ihit = 1; halt = 1;
        stepCycle();
        checks++;
        if (halted !== 1'b1 || imemREN !== 1'b0 || imemaddr !== 32'h30) begin
            failures++;
            $display("[TB] FAIL halt_enter: halted=%b iren=%b pc=%h, want 1/0/00000030", halted, imemREN, imemaddr);
        end
        badCycles = 0;
        for (int i = 0; i < 10; i++) begin
            ihit = i[0]; dhit = ~i[0]; halt = 0; dREN = i[1]; dWEN = i[2];
            JumpSel = 2'b10; rs_data = 32'h1234_5678;
            stepCycle();
            if (halted !== 1'b1 || imemaddr !== 32'h30 || imemREN !== 1'b0 || dmemREN !== 1'b0 || dmemWEN !== 1'b0)
                badCycles++;
        end
        checks++;
        if (badCycles !== 0) begin
            failures++;
            $display("[TB] FAIL halt_hold: %0d bad cycles, want 0", badCycles);
        end
        clearInputs();
        nRST = 0;
        #2;
        nRST = 1;
        #1;
        checks++;
        if (imemaddr !== 32'h0 || halted !== 1'b0 || imemREN !== 1'b1) begin
            failures++;
            $display("[TB] FAIL halt_reset: pc=%h halted=%b iren=%b, want 00000000/0/1", imemaddr, halted, imemREN);
        end
    endtask

    task automatic test_reset_mid_data();
        setPc(32'h50);
        imemload = 32'hAC22_0000;
        ihit = 1; dWEN = 1;
        stepCycle();
        clearInputs();
        checks++;
        if (dmemWEN !== 1'b1) begin
            failures++;
            $display("[TB] FAIL store_req: dwen=%b, want 1", dmemWEN);
        end
        #2;
        nRST = 0;
        #1;
        checks++;
        if (dmemWEN !== 1'b0 || dmemREN !== 1'b0 || imemREN !== 1'b1 || imemaddr !== 32'h0) begin
            failures++;
            $display("[TB] FAIL reset_mid_data: dwen=%b dren=%b iren=%b pc=%h, want 0/0/1/00000000",
                     dmemWEN, dmemREN, imemREN, imemaddr);
        end
        stepCycle();
        nRST = 1;
    endtask

    initial begin
        test_reset();
        test_sequential();
        test_load();
        test_branch();
        test_jump();
        test_wrap();
        test_both_dmem();
        test_halt();
        test_reset_mid_data();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
